// File: rtl/alu_op_issue.sv
// alu_op_issue: issue stage in front of the 64-bit ALU.
// Decodes an RV64 instruction word together with its register-file read data
// into an {a, b, ALUop, illegal} entry, and buffers up to two entries between
// decode and execute with valid/ready handshakes on both sides.
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   in_valid/in_ready   input handshake for instr, rs1_data, rs2_data
//   instr               32-bit instruction word
//   rs1_data, rs2_data  register-file read data (DATA_W bits)
//   out_valid/out_ready output handshake for the head entry
//   a, b                ALU operands of the head entry
//   ALUop               4-bit ALU operation of the head entry
//   illegal             head entry holds an unsupported instruction
module alu_op_issue #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [3:0]        ALUop,
    output logic              illegal
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        op;
        logic              ill;
    } entry_t;

    // Occupancy of the buffer; the encoding equals the entry count.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_e;

    state_e state_q;
    entry_t head_q;
    entry_t tail_q;
    entry_t new_d;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_s;
    logic [1:0]        count;
    logic              push;
    logic              pop;
    logic              unused_rs1_field;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{(DATA_W-12){instr[31]}}, instr[31:20]};
    assign imm_s  = {{(DATA_W-12){instr[31]}}, instr[31:25], instr[11:7]};

    // Register specifier rs1 is resolved upstream by the register-file read.
    assign unused_rs1_field = ^instr[19:15];

    always_comb begin
        new_d     = '0;
        new_d.ill = 1'b1;
        case (opcode)
            OPC_REG: begin
                if (funct7 == 7'b0000000 && funct3 == 3'b000) begin
                    new_d = '{a: rs1_data, b: rs2_data, op: ALU_ADD, ill: 1'b0};
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    new_d = '{a: rs1_data, b: rs2_data, op: ALU_SUB, ill: 1'b0};
                end else if (funct7 == 7'b0000000 && funct3 == 3'b111) begin
                    new_d = '{a: rs1_data, b: rs2_data, op: ALU_AND, ill: 1'b0};
                end else if (funct7 == 7'b0000000 && funct3 == 3'b110) begin
                    new_d = '{a: rs1_data, b: rs2_data, op: ALU_OR, ill: 1'b0};
                end
            end
            OPC_IMM: begin
                case (funct3)
                    3'b000:  new_d = '{a: rs1_data, b: imm_i, op: ALU_ADD, ill: 1'b0};
                    3'b111:  new_d = '{a: rs1_data, b: imm_i, op: ALU_AND, ill: 1'b0};
                    3'b110:  new_d = '{a: rs1_data, b: imm_i, op: ALU_OR,  ill: 1'b0};
                    default: ;
                endcase
            end
            OPC_LOAD: begin
                if (funct3 == 3'b011) begin
                    new_d = '{a: rs1_data, b: imm_i, op: ALU_ADD, ill: 1'b0};
                end
            end
            OPC_STORE: begin
                if (funct3 == 3'b011) begin
                    new_d = '{a: rs1_data, b: imm_s, op: ALU_ADD, ill: 1'b0};
                end
            end
            OPC_BRANCH: begin
                if (funct3 == 3'b000) begin
                    new_d = '{a: rs1_data, b: rs2_data, op: ALU_SUB, ill: 1'b0};
                end
            end
            default: ;
        endcase
    end

    // in_ready depends on registered occupancy only, never on out_ready.
    assign count     = state_q;
    assign in_ready  = (count != 2'(DEPTH));
    assign out_valid = (state_q != S_EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_ready & out_valid;

    // The head register doubles as the output register, so it keeps its
    // contents when the buffer empties and the outputs hold their last values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        head_q  <= new_d;
                        state_q <= S_ONE;
                    end
                end
                S_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_q  <= new_d;
                            state_q <= S_FULL;
                        end
                        2'b01: state_q <= S_EMPTY;
                        2'b11: head_q  <= new_d;
                        default: ;
                    endcase
                end
                S_FULL: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= S_ONE;
                    end
                end
                default: state_q <= S_EMPTY;
            endcase
        end
    end

    assign a       = head_q.a;
    assign b       = head_q.b;
    assign ALUop   = head_q.op;
    assign illegal = head_q.ill;

endmodule

// File: tb/tb_alu_op_issue.sv
module tb_alu_op_issue;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [3:0]  ALUop;
    logic        illegal;

    alu_op_issue #(.DATA_W(64), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .ALUop     (ALUop),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   vectors = 0;
    int   miscompares = 0;
    int   delivered = 0;
    int   accepted = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the instruction-class rules.
    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] r1,
                                     input logic [63:0] r2);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        longint      imm_i;
        longint      imm_s;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = longint'($signed(ins)) >>> 20;
        imm_s = ((longint'($signed(ins)) >>> 25) <<< 5) | longint'(ins[11:7]);
        e = '{a: 64'd0, b: 64'd0, op: 4'd0, ill: 1'b1};
        if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd0) e = '{r1, r2, 4'd2, 1'b0};
        if (opc == 7'h33 && f7 == 7'h20 && f3 == 3'd0) e = '{r1, r2, 4'd6, 1'b0};
        if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd7) e = '{r1, r2, 4'd0, 1'b0};
        if (opc == 7'h33 && f7 == 7'h00 && f3 == 3'd6) e = '{r1, r2, 4'd1, 1'b0};
        if (opc == 7'h13 && f3 == 3'd0) e = '{r1, 64'(imm_i), 4'd2, 1'b0};
        if (opc == 7'h13 && f3 == 3'd7) e = '{r1, 64'(imm_i), 4'd0, 1'b0};
        if (opc == 7'h13 && f3 == 3'd6) e = '{r1, 64'(imm_i), 4'd1, 1'b0};
        if (opc == 7'h03 && f3 == 3'd3) e = '{r1, 64'(imm_i), 4'd2, 1'b0};
        if (opc == 7'h23 && f3 == 3'd3) e = '{r1, 64'(imm_s), 4'd2, 1'b0};
        if (opc == 7'h63 && f3 == 3'd0) e = '{r1, r2, 4'd6, 1'b0};
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, r2, r1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] r1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, r1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] r2,
                                          input logic [4:0] r1, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {imm[11:5], r2, r1, f3, imm[4:0], opc};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  f3;
        w = $urandom;
        case ($urandom_range(0, 9))
            0: return enc_r(7'h00, w[24:20], w[19:15], 3'd0, w[11:7], 7'h33);
            1: return enc_r(7'h20, w[24:20], w[19:15], 3'd0, w[11:7], 7'h33);
            2: return enc_r(7'h00, w[24:20], w[19:15], 3'd7, w[11:7], 7'h33);
            3: return enc_r(7'h00, w[24:20], w[19:15], 3'd6, w[11:7], 7'h33);
            4: begin
                f3 = ($urandom_range(0, 2) == 0) ? 3'd0 : (w[0] ? 3'd7 : 3'd6);
                return enc_i(w[31:20], w[19:15], f3, w[11:7], 7'h13);
            end
            5: return enc_i(w[31:20], w[19:15], 3'd3, w[11:7], 7'h03);
            6: return enc_s(w[31:20], w[24:20], w[19:15], 3'd3, 7'h23);
            7: return enc_s(w[31:20], w[24:20], w[19:15], 3'd0, 7'h63);
            8: return enc_r(w[31:25], w[24:20], w[19:15], w[14:12], w[11:7], 7'h33);
            default: return w;
        endcase
    endfunction

    task automatic model_edge();
        int   n;
        exp_t e;
        n = q.size();
        if (reset) begin
            q.delete();
            last = '{64'd0, 64'd0, 4'd0, 1'b0};
        end else begin
            if (out_ready && n > 0) begin
                e = q.pop_front();
                delivered++;
            end
            if (in_valid && n < 2) begin
                q.push_back(ref_dec(instr, rs1_data, rs2_data));
                accepted++;
            end
            if (q.size() > 0) last = q[0];
        end
    endtask

    task automatic check_model();
        exp_t e;
        e = (q.size() > 0) ? q[0] : last;
        chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
        chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
        chk("a", a, e.a);
        chk("b", b, e.b);
        chk("ALUop", 64'(ALUop), 64'(e.op));
        chk("illegal", 64'(illegal), 64'(e.ill));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [63:0] r1,
                         input logic [63:0] r2);
        in_valid = v;
        instr    = ins;
        rs1_data = r1;
        rs2_data = r2;
    endtask

    task automatic sweep_one(input string name, input logic [31:0] ins, input logic [3:0] eop,
                             input logic [63:0] ea, input logic [63:0] eb, input logic eill);
        drive(1'b1, ins, 64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321);
        step();
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_op"}, 64'(ALUop), 64'(eop));
        chk({name, "_a"}, a, ea);
        chk({name, "_b"}, b, eb);
        chk({name, "_ill"}, 64'(illegal), 64'(eill));
    endtask

    localparam logic [63:0] R1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] R2 = 64'h0FED_CBA9_8765_4321;

    initial begin
        int unsigned cyc;
        int          base;
        reset     = 1'b1;
        out_ready = 1'b0;
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        last = '{64'd0, 64'd0, 4'd0, 1'b0};

        // Reset state
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_a", a, 64'd0);
        chk("rst_op", 64'(ALUop), 64'd0);
        step();
        step();
        reset = 1'b0;

        // Decode sweep with out_ready held high
        out_ready = 1'b1;
        sweep_one("add", enc_r(7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 4'b0010, R1, R2, 1'b0);
        sweep_one("sub", enc_r(7'h20, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33), 4'b0110, R1, R2, 1'b0);
        sweep_one("and", enc_r(7'h00, 5'd3, 5'd2, 3'd7, 5'd1, 7'h33), 4'b0000, R1, R2, 1'b0);
        sweep_one("or",  enc_r(7'h00, 5'd3, 5'd2, 3'd6, 5'd1, 7'h33), 4'b0001, R1, R2, 1'b0);
        sweep_one("addi", enc_i(12'hFFF, 5'd2, 3'd0, 5'd1, 7'h13), 4'b0010, R1,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        sweep_one("ld", enc_i(12'h7FF, 5'd2, 3'd3, 5'd1, 7'h03), 4'b0010, R1, 64'h7FF, 1'b0);
        sweep_one("sd", enc_s(12'd8, 5'd3, 5'd2, 3'd3, 7'h23), 4'b0010, R1, 64'd8, 1'b0);
        sweep_one("sd_neg", enc_s(12'hFF0, 5'd3, 5'd2, 3'd3, 7'h23), 4'b0010, R1,
                  64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        sweep_one("beq", enc_s(12'd16, 5'd3, 5'd2, 3'd0, 7'h63), 4'b0110, R1, R2, 1'b0);
        sweep_one("ecall", 32'h0000_0073, 4'b0000, 64'd0, 64'd0, 1'b1);
        sweep_one("add2", enc_r(7'h00, 5'd5, 5'd4, 3'd0, 5'd6, 7'h33), 4'b0010, R1, R2, 1'b0);
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        step();
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: four offered, two accepted
        out_ready = 1'b0;
        base = accepted;
        for (int unsigned i = 0; i < 4; i++) begin
            drive(1'b1, enc_r(7'h20, 5'd1, 5'd1, 3'd0, 5'd1, 7'h33),
                  64'h11 * 64'(i + 1), 64'h5);
            step();
        end
        chk("bp_accepted", 64'(accepted - base), 64'd2);
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_head_a", a, 64'h11);
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp_pop1_a", a, 64'h22);
        chk("bp_pop1_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("bp_pop2_valid", 64'(out_valid), 64'd0);

        // Empty pops leave the held outputs untouched
        for (int unsigned i = 0; i < 5; i++) step();
        chk("empty_valid", 64'(out_valid), 64'd0);
        chk("empty_hold_a", a, 64'h22);
        chk("empty_hold_op", 64'(ALUop), 64'b0110);

        // Random push/pop traffic
        base = delivered;
        cyc  = 0;
        while (delivered - base < 1000 && cyc < 8000) begin
            drive(1'($urandom_range(0, 3) != 0), rand_instr(),
                  {$urandom, $urandom}, {$urandom, $urandom});
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
            cyc++;
        end
        chk("rand_delivered", 64'(delivered - base), 64'd1000);

        // Reset between edges with two entries held
        out_ready = 1'b0;
        for (int unsigned i = 0; i < 2; i++) begin
            drive(1'b1, rand_instr(), {$urandom, $urandom}, {$urandom, $urandom});
            step();
        end
        chk("pre_rst_in_ready", 64'(in_ready), 64'd0);
        #2;
        reset = 1'b1;
        q.delete();
        last = '{64'd0, 64'd0, 4'd0, 1'b0};
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_op", 64'(ALUop), 64'd0);
        chk("mid_rst_a", a, 64'd0);
        chk("mid_rst_b", b, 64'd0);
        chk("mid_rst_ill", 64'(illegal), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        step();
        reset = 1'b0;
        base = delivered;
        drive(1'b1, enc_r(7'h00, 5'd3, 5'd2, 3'd6, 5'd1, 7'h33), 64'hA5, 64'h5A);
        step();
        chk("post_rst_op", 64'(ALUop), 64'b0001);
        chk("post_rst_a", a, 64'hA5);
        drive(1'b0, 32'd0, 64'd0, 64'd0);
        out_ready = 1'b1;
        step();
        step();
        chk("post_rst_delivered", 64'(delivered - base), 64'd1);
        chk("post_rst_empty", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
